alu_op_issue: RTL and testbench

- Operand issue stage directly upstream of the clocked xnor ALU.
- Accepts operand/opcode triples over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU's op/en/A/B inputs one operation at a time, then captures the 6-bit ALU result after a fixed latency.
- Presents the result downstream over a second valid/ready interface.

---
 rtl/alu_op_issue.sv | 209 ++++++++++++++++++++
 tb/tb_alu_op_issue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issue.sv
// alu_op_issue: operand issue stage in front of the clocked xnor ALU.
//
// Operand/opcode triples arrive over a valid/ready port and wait in a small
// FIFO. A three-state FSM pops one triple at a time and drives it to the ALU
// with a one-cycle alu_en strobe. It counts ALU_LAT cycles, captures alu_dout,
// and holds the result on a second valid/ready port until downstream accepts it.
//
// Parameters:
//   DEPTH   - FIFO entries (power of two, >= 2)
//   ALU_LAT - edges from the alu_en sampling edge to alu_dout valid (1..7)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              upstream handshake (in_ready = !full)
//   in_a, in_b, in_op              operand A, operand B, opcode
//   alu_en, alu_op, alu_a, alu_b   registered drive to the ALU
//   alu_dout                       ALU result
//   res_valid/res_ready            downstream handshake
//   res_data, res_op               captured result and its opcode
//
// Optional build macro ALU_OP_ISSUE_COUNT_EN:
//   adds issue_count (8-bit, counts alu_en cycles, wraps) and
//   fifo_level (current FIFO occupancy).
module alu_op_issue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  input  logic [1:0] in_op,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  input  logic [5:0] alu_dout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_data,
  output logic [1:0] res_op
`ifdef ALU_OP_ISSUE_COUNT_EN
  ,
  output logic [7:0] issue_count,
  output logic [$clog2(DEPTH):0] fifo_level
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = 3;

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // FIFO storage: each entry packs {op, a, b}
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic [7:0] head_s;

  state_e         state_q;
  logic [LAT_W-1:0] lat_q;
  logic           alu_en_q;
  logic [1:0]     alu_op_q;
  logic [2:0]     alu_a_q;
  logic [2:0]     alu_b_q;
  logic           res_valid_q;
  logic [5:0]     res_data_q;
  logic [1:0]     res_op_q;

  // in_ready depends only on registered occupancy, so a same-cycle pop
  // never lets a push in while full.
  assign full_s   = (count_q == CNT_FULL);
  assign empty_s  = (count_q == CNT_ZERO);
  assign in_ready = !full_s;
  assign push_s   = in_valid && !full_s;
  assign pop_s    = (state_q == S_IDLE) && !empty_s;
  assign head_s   = mem_q[rd_ptr_q];

  // Occupancy next-state from the push/pop pair
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents are meaningless once pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_op, in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // Issue FSM with registered ALU drive and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lat_q       <= {LAT_W{1'b0}};
      alu_en_q    <= 1'b0;
      alu_op_q    <= 2'b00;
      alu_a_q     <= 3'b000;
      alu_b_q     <= 3'b000;
      res_valid_q <= 1'b0;
      res_data_q  <= 6'b000000;
      res_op_q    <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          alu_en_q <= 1'b0;
          if (!empty_s) begin
            alu_op_q <= head_s[7:6];
            alu_a_q  <= head_s[5:3];
            alu_b_q  <= head_s[2:0];
            alu_en_q <= 1'b1;
            lat_q    <= LAT_LOAD;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The counter hits zero on the cycle alu_dout becomes valid
          alu_en_q <= 1'b0;
          if (lat_q == {LAT_W{1'b0}}) begin
            res_data_q  <= alu_dout;
            res_op_q    <= alu_op_q;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          alu_en_q    <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign alu_en    = alu_en_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

`ifdef ALU_OP_ISSUE_COUNT_EN
  logic [7:0] issue_count_q;

  // Counts issue strobes; 8-bit wrap is intended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q <= 8'd0;
    end else if (alu_en_q) begin
      issue_count_q <= issue_count_q + 8'd1;
    end
  end

  assign issue_count = issue_count_q;
  assign fifo_level  = count_q;
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: accepted triples push their expected
// {op, data} into a queue; a monitor pops and compares on each result handshake.
module tb_alu_op_issue;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_a;
  logic [2:0] in_b;
  logic [1:0] in_op;
  logic [5:0] in_exp;
  logic       alu_en;
  logic [1:0] alu_op;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [5:0] alu_dout;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_data;
  logic [1:0] res_op;
`ifdef ALU_OP_ISSUE_COUNT_EN
  logic [7:0] issue_count;
  logic [$clog2(DEPTH):0] fifo_level;
`endif

  int checks;
  int errors;
  int n_results;
  logic [7:0] sb[$];

  alu_op_issue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_dout(alu_dout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op)
`ifdef ALU_OP_ISSUE_COUNT_EN
    , .issue_count(issue_count), .fifo_level(fifo_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model (ALU_LAT = 1): op 00 -> xnor, other ops -> {A, B}
  initial alu_dout = 6'b000000;
  always @(posedge clk) begin
    if (alu_en) begin
      if (alu_op == 2'b00) alu_dout <= {3'b000, ~(alu_a ^ alu_b)};
      else                 alu_dout <= {alu_a, alu_b};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop/compare, hold stability, push recording
  initial begin : monitor
    logic       prev_stall;
    logic [7:0] prev_res;
    logic [7:0] exp_v;
`ifdef ALU_OP_ISSUE_COUNT_EN
    int push_cnt;
    int en_cnt;
    push_cnt = 0;
    en_cnt   = 0;
`endif
    prev_stall = 1'b0;
    prev_res   = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
`ifdef ALU_OP_ISSUE_COUNT_EN
        push_cnt = 0;
        en_cnt   = 0;
`endif
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, res_valid}, 32'd1);
          chk("hold_stable", {24'd0, res_op, res_data}, {24'd0, prev_res});
        end
        prev_stall = res_valid && !res_ready;
        prev_res   = {res_op, res_data};
        if (res_valid && res_ready) begin
          n_results++;
          if (sb.size() == 0) begin
            chk("unexpected_result", {24'd0, res_op, res_data}, 32'hFFFF_FFFF);
          end else begin
            exp_v = sb.pop_front();
            chk("result", {24'd0, res_op, res_data}, {24'd0, exp_v});
          end
        end
`ifdef ALU_OP_ISSUE_COUNT_EN
        if (alu_en) en_cnt++;
        chk("fifo_level", 32'(fifo_level), 32'(push_cnt - en_cnt));
        if (in_valid && in_ready) push_cnt++;
`endif
        if (in_valid && in_ready) sb.push_back({in_op, in_exp});
      end
    end
  end

  // Offer one triple and hold it until accepted (bounded)
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                      input logic [5:0] exp);
    logic acc;
    in_a = a; in_b = b; in_op = op; in_exp = exp; in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !res_valid;
    end
    if (!done) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin : stim
    int n;
    int start_res;
    logic hit;
    checks = 0; errors = 0; n_results = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = 3'b000; in_b = 3'b000; in_op = 2'b00;
    in_exp = 6'b000000; res_ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rst_alu_regs", {24'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("rst_res_regs", {24'd0, res_op, res_data}, 32'd0);
`ifdef ALU_OP_ISSUE_COUNT_EN
    chk("rst_issue_count", {24'd0, issue_count}, 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("idle_alu_en", {31'd0, alu_en}, 32'd0);
    @(posedge clk); #1;

    // Single op
    res_ready = 1'b1;
    send(3'b011, 3'b001, 2'b00, 6'b000101);
    hit = 1'b0; n = 0;
    for (int t = 0; t < 10 && !hit; t++) begin
      @(negedge clk);
      n++;
      hit = alu_en;
    end
    chk("issue_seen", {31'd0, hit}, 32'd1);
    chk("issue_latency", 32'(n), 32'd2);
    chk("issue_operands", {24'd0, alu_op, alu_a, alu_b}, {24'd0, 2'b00, 3'b011, 3'b001});
    @(negedge clk);
    chk("alu_en_one_cycle", {31'd0, alu_en}, 32'd0);
    chk("res_not_early", {31'd0, res_valid}, 32'd0);
    chk("operands_stable", {26'd0, alu_a, alu_b}, {26'd0, 3'b011, 3'b001});
    @(negedge clk);
    chk("res_valid_t2", {31'd0, res_valid}, 32'd1);
    chk("res_single", {24'd0, res_op, res_data}, {24'd0, 2'b00, 6'b000101});
    wait_drain();

    // Fill to full under backpressure
    @(posedge clk); #1;
    res_ready = 1'b0;
    start_res = n_results;
    send(3'b001, 3'b010, 2'b00, 6'b000100);
    send(3'b101, 3'b110, 2'b01, 6'b101110);
    send(3'b111, 3'b000, 2'b10, 6'b111000);
    send(3'b010, 3'b010, 2'b00, 6'b000111);
    send(3'b100, 3'b001, 2'b11, 6'b100001);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_a = 3'b110; in_b = 3'b011; in_op = 2'b00; in_exp = 6'b000010; in_valid = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("held_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    send(3'b110, 3'b011, 2'b00, 6'b000010);
    wait_drain();
    chk("fill_result_count", 32'(n_results - start_res), 32'd6);

    // Backpressure hold
    @(posedge clk); #1;
    res_ready = 1'b0;
    send(3'b111, 3'b111, 2'b00, 6'b000111);
    send(3'b010, 3'b101, 2'b00, 6'b000000);
    hit = 1'b0;
    for (int t = 0; t < 20 && !hit; t++) begin
      @(negedge clk);
      hit = res_valid;
    end
    chk("bp_res_seen", {31'd0, hit}, 32'd1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data", {26'd0, res_data}, {26'd0, 6'b000111});
      chk("bp_no_issue", {31'd0, alu_en}, 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_no_issue", {31'd0, alu_en}, 32'd0);
    @(negedge clk);
    chk("post_hs_no_issue", {31'd0, alu_en}, 32'd0);
    @(negedge clk);
    chk("issue_after_hs", {31'd0, alu_en}, 32'd1);
    wait_drain();

    // Reset mid-flight: op in WAIT, two entries pending
    @(posedge clk); #1;
    send(3'b101, 3'b011, 2'b01, 6'b101011);
    send(3'b001, 3'b001, 2'b00, 6'b000111);
    send(3'b011, 3'b110, 2'b00, 6'b000010);
    chk("mid_issued_op", {24'd0, alu_op, alu_a, alu_b}, {24'd0, 2'b01, 3'b101, 3'b011});
    #2 rst_n = 1'b0;
    #1;
    chk("async_alu_regs", {24'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("async_alu_en", {31'd0, alu_en}, 32'd0);
    chk("async_res", {23'd0, res_valid, res_op, res_data}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("post_rst_quiet", {30'd0, res_valid, alu_en}, 32'd0);
    end

`ifdef ALU_OP_ISSUE_COUNT_EN
    // 258 ops: issue counter wraps to 2
    @(posedge clk); #1;
    for (int i = 0; i < 258; i++) begin
      send(i[2:0], i[5:3], 2'b00, {3'b000, ~(i[2:0] ^ i[5:3])});
    end
    wait_drain();
    chk("issue_count_wrap", {24'd0, issue_count}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
